// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter (mem_arbiter and mem_arb_pick).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin on last_owner; otherwise data beats fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
`ifdef MEM_ARB_RR_EN
    input  arb_owner_t last_owner,
`endif
    output arb_owner_t winner
);

    always_comb begin
        winner = OWN_I;
`ifdef MEM_ARB_RR_EN
        // On a tie the side that was not granted last time goes first.
        if (i_req && d_req) begin
            winner = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            winner = OWN_D;
        end
`else
        if (d_req) begin
            winner = OWN_D;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and load/store, one transaction in flight.
// Optional MEM_ARB_RR_EN: round-robin arbitration instead of data-over-fetch priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_gnt,
    input  logic          m_rvalid,
    input  logic [DW-1:0] m_rdata
);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    arb_owner_t winner;
    arb_owner_t cur_owner;
    logic       drive_mem;
    logic       grant;

`ifdef MEM_ARB_RR_EN
    arb_owner_t last_owner_q, last_owner_d;

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_owner (last_owner_q),
        .winner     (winner)
    );

    always_comb begin
        last_owner_d = last_owner_q;
        if (grant) begin
            last_owner_d = cur_owner;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= OWN_I;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    mem_arb_pick u_pick (
        .i_req  (i_req),
        .d_req  (d_req),
        .winner (winner)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_I;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cur_owner = owner_q;
        drive_mem = 1'b0;
        grant     = 1'b0;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    drive_mem = 1'b1;
                    cur_owner = winner;
                    owner_d   = winner;
                    grant     = m_gnt;
                    state_d   = m_gnt ? ST_RESP : ST_REQ;
                end
            end
            // Ownership is locked once presented; a late request from the other side waits.
            ST_REQ: begin
                drive_mem = 1'b1;
                if (m_gnt) begin
                    grant   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (m_rvalid) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_D) begin
                        d_rvalid = 1'b1;
                        d_rdata  = m_rdata;
                    end else begin
                        i_rvalid = 1'b1;
                        i_rdata  = m_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant) begin
            if (cur_owner == OWN_D) begin
                d_gnt = 1'b1;
            end else begin
                i_gnt = 1'b1;
            end
        end
    end

    // Memory-side fields stay at zero unless a request is actually being presented.
    always_comb begin
        m_req   = drive_mem;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (drive_mem) begin
            if (cur_owner == OWN_D) begin
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end else begin
                m_addr  = i_addr;
            end
        end
    end

    a_i_hold: assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_REQ && owner_q == OWN_I) |-> (i_req && $stable(i_addr)));

    a_d_hold: assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_REQ && owner_q == OWN_D) |-> (d_req && $stable(d_addr) && $stable(d_we)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester drivers, a wait-state memory model and a monitor.
// Round-robin expectations are selected with MEM_ARB_RR_EN.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dop_t;

    typedef struct packed {
        logic        own_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_req_t;

    typedef struct packed {
        logic        own_d;
        logic [31:0] rdata;
    } exp_rsp_t;

    logic [31:0] i_q[$];
    dop_t        d_q[$];
    exp_req_t    exp_req_q[$];
    exp_rsp_t    exp_rsp_q[$];
    int          i_gnt_cyc[$];
    int          i_rv_cyc[$];
    int          d_gnt_cyc[$];
    int          d_rv_cyc[$];

    int n_cmp;
    int n_bad;
    int cyc;
    int gnt_delay;
    int rsp_delay;
    bit inject_rv;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time expired");
        $fatal(1, "[TB] watchdog");
    end

    // Fetch requester: holds the head address until granted.
    initial begin : i_driver
        i_req  = 1'b0;
        i_addr = '0;
        forever begin
            @(negedge clk);
            if (!reset && i_req && i_gnt && i_q.size() > 0) i_q.delete(0);
            @(posedge clk);
            #1;
            if (!reset && i_q.size() > 0) begin
                i_req  = 1'b1;
                i_addr = i_q[0];
            end else begin
                i_req  = 1'b0;
                i_addr = '0;
            end
        end
    end

    // Data requester: holds we/addr/wdata until granted.
    initial begin : d_driver
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        forever begin
            @(negedge clk);
            if (!reset && d_req && d_gnt && d_q.size() > 0) d_q.delete(0);
            @(posedge clk);
            #1;
            if (!reset && d_q.size() > 0) begin
                d_req   = 1'b1;
                d_we    = d_q[0].we;
                d_addr  = d_q[0].addr;
                d_wdata = d_q[0].wdata;
            end else begin
                d_req   = 1'b0;
                d_we    = 1'b0;
                d_addr  = '0;
                d_wdata = '0;
            end
        end
    end

    // Memory: grants after gnt_delay stalled cycles, answers rsp_delay cycles after the grant.
    initial begin : mem_model
        int          wait_cnt;
        int          rsp_cnt;
        bit          pend;
        logic [31:0] pend_addr;
        wait_cnt  = 0;
        rsp_cnt   = 0;
        pend      = 1'b0;
        pend_addr = '0;
        m_gnt     = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend     = 1'b0;
                wait_cnt = 0;
            end else if (m_req && m_gnt) begin
                pend      = 1'b1;
                rsp_cnt   = rsp_delay;
                pend_addr = m_addr;
                wait_cnt  = 0;
            end else if (m_req) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
            end
            @(posedge clk);
            #2;
            m_rvalid = 1'b0;
            m_rdata  = '0;
            if (pend) begin
                rsp_cnt--;
                if (rsp_cnt <= 0) begin
                    m_rvalid = 1'b1;
                    m_rdata  = mem_data(pend_addr);
                    pend     = 1'b0;
                end
            end else if (inject_rv) begin
                m_rvalid  = 1'b1;
                m_rdata   = 32'h1234_5678;
                inject_rv = 1'b0;
            end
            m_gnt = m_req && (wait_cnt >= gnt_delay);
        end
    end

    // Scoreboard: grants pop expected requests, memory responses pop expected routing.
    initial begin : monitor
        exp_req_t e;
        exp_rsp_t r;
        logic [98:0] got_req, want_req;
        logic [65:0] got_rsp, want_rsp;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (i_gnt)    i_gnt_cyc.push_back(cyc);
                if (d_gnt)    d_gnt_cyc.push_back(cyc);
                if (i_rvalid) i_rv_cyc.push_back(cyc);
                if (d_rvalid) d_rv_cyc.push_back(cyc);

                n_cmp++;
                if (m_req && m_gnt) begin
                    if (exp_req_q.size() == 0) begin
                        n_bad++;
                        $display("[TB] FAIL sb_grant: unexpected grant, m_addr=%h, nothing expected", m_addr);
                    end else begin
                        e = exp_req_q.pop_front();
                        got_req  = {d_gnt, i_gnt, m_we, m_addr, m_wdata};
                        want_req = {e.own_d, ~e.own_d, e.we, e.addr, e.wdata};
                        if (got_req !== want_req) begin
                            n_bad++;
                            $display("[TB] FAIL sb_grant: got dgnt/ignt/we/addr/wdata=%h required %h", got_req, want_req);
                        end
                        r.own_d = e.own_d;
                        r.rdata = mem_data(e.addr);
                        exp_rsp_q.push_back(r);
                    end
                end else if ({i_gnt, d_gnt} !== 2'b00) begin
                    n_bad++;
                    $display("[TB] FAIL sb_spurious_gnt: got i_gnt/d_gnt=%b required 00", {i_gnt, d_gnt});
                end

                n_cmp++;
                if (m_rvalid && exp_rsp_q.size() > 0) begin
                    r = exp_rsp_q.pop_front();
                    got_rsp  = {i_rvalid, d_rvalid, i_rdata, d_rdata};
                    want_rsp = {~r.own_d, r.own_d, r.own_d ? 32'h0 : r.rdata, r.own_d ? r.rdata : 32'h0};
                    if (got_rsp !== want_rsp) begin
                        n_bad++;
                        $display("[TB] FAIL sb_resp: got irv/drv/irdata/drdata=%h required %h", got_rsp, want_rsp);
                    end
                end else if ({i_rvalid, d_rvalid, i_rdata, d_rdata} !== 66'h0) begin
                    n_bad++;
                    $display("[TB] FAIL sb_idle_resp: got irv/drv/irdata/drdata=%h required 0",
                             {i_rvalid, d_rvalid, i_rdata, d_rdata});
                end
            end
        end
    end

    task automatic clear_logs();
        i_gnt_cyc.delete();
        i_rv_cyc.delete();
        d_gnt_cyc.delete();
        d_rv_cyc.delete();
    endtask

    task automatic push_i(input logic [31:0] a);
        exp_req_t e;
        i_q.push_back(a);
        e.own_d = 1'b0;
        e.we    = 1'b0;
        e.addr  = a;
        e.wdata = '0;
        exp_req_q.push_back(e);
    endtask

    task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input bit expect_now);
        dop_t     op;
        exp_req_t e;
        op.we    = we;
        op.addr  = a;
        op.wdata = wd;
        d_q.push_back(op);
        e.own_d = 1'b1;
        e.we    = we;
        e.addr  = a;
        e.wdata = wd;
        if (expect_now) exp_req_q.push_back(e);
    endtask

    task automatic expect_req(input logic own_d, input logic we, input logic [31:0] a, input logic [31:0] wd);
        exp_req_t e;
        e.own_d = own_d;
        e.we    = we;
        e.addr  = a;
        e.wdata = wd;
        exp_req_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (i_q.size() == 0 && d_q.size() == 0 && exp_req_q.size() == 0 && exp_rsp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_we, m_addr, m_wdata} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got nonzero outputs m_req=%b m_addr=%h, required all 0", m_req, m_addr);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({i_gnt, d_gnt, m_req, m_addr} !== '0) begin
            n_bad++;
            $display("[TB] FAIL post_reset_idle: got m_req=%b m_addr=%h required 0/0", m_req, m_addr);
        end
    endtask

    task automatic test_fetch_stream();
        int c0;
        bit ok;
        gnt_delay = 0;
        rsp_delay = 1;
        clear_logs();
        c0 = cyc + 1;
        push_i(32'h0);
        push_i(32'h4);
        push_i(32'h8);
        wait_drain(40, ok);
        n_cmp++;
        if (!ok || i_gnt_cyc.size() != 3 || i_rv_cyc.size() != 3 || d_gnt_cyc.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL fetch_stream_count: got gnt=%0d rv=%0d required 3/3", i_gnt_cyc.size(), i_rv_cyc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (i_gnt_cyc[k] != c0 + 2 * k || i_rv_cyc[k] != c0 + 2 * k + 1) begin
                    n_bad++;
                    $display("[TB] FAIL fetch_stream_timing[%0d]: got gnt/rv at %0d/%0d required %0d/%0d",
                             k, i_gnt_cyc[k] - c0, i_rv_cyc[k] - c0, 2 * k, 2 * k + 1);
                end
            end
        end
    endtask

    task automatic test_priority();
        int c0;
        bit ok;
        clear_logs();
        c0 = cyc + 1;
        push_d(1'b1, 32'h64, 32'hDEAD_BEEF, 1'b1);
        push_i(32'h100);
        wait_drain(40, ok);
        n_cmp++;
        if (!ok || d_gnt_cyc.size() != 1 || d_rv_cyc.size() != 1 || i_gnt_cyc.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL priority_count: got dgnt=%0d drv=%0d ignt=%0d required 1/1/1",
                     d_gnt_cyc.size(), d_rv_cyc.size(), i_gnt_cyc.size());
        end else begin
            n_cmp++;
            if (d_gnt_cyc[0] != c0 || d_rv_cyc[0] != c0 + 1 || i_gnt_cyc[0] != c0 + 2) begin
                n_bad++;
                $display("[TB] FAIL priority_timing: got dgnt/drv/ignt at %0d/%0d/%0d required 0/1/2",
                         d_gnt_cyc[0] - c0, d_rv_cyc[0] - c0, i_gnt_cyc[0] - c0);
            end
        end
    endtask

    task automatic test_gnt_stall();
        int c0;
        bit ok;
        gnt_delay = 3;
        clear_logs();
        c0 = cyc + 1;
        push_i(32'h200);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) push_d(1'b0, 32'h300, 32'h0, 1'b1);
            n_cmp++;
            if (m_req !== 1'b1 || m_addr !== 32'h200 || m_we !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL stall_hold[%0d]: got m_req=%b m_addr=%h required 1/00000200", k, m_req, m_addr);
            end
        end
        wait_drain(60, ok);
        n_cmp++;
        if (!ok || i_gnt_cyc.size() != 1 || i_rv_cyc.size() != 1 || d_gnt_cyc.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL stall_count: got ignt=%0d irv=%0d dgnt=%0d required 1/1/1",
                     i_gnt_cyc.size(), i_rv_cyc.size(), d_gnt_cyc.size());
        end else begin
            n_cmp++;
            if (i_gnt_cyc[0] != c0 + 3 || d_gnt_cyc[0] <= i_rv_cyc[0]) begin
                n_bad++;
                $display("[TB] FAIL stall_timing: got ignt=%0d irv=%0d dgnt=%0d required ignt=3, dgnt after irv",
                         i_gnt_cyc[0] - c0, i_rv_cyc[0] - c0, d_gnt_cyc[0] - c0);
            end
        end
        gnt_delay = 0;
    endtask

    task automatic test_slow_resp();
        int c0;
        bit ok;
        rsp_delay = 5;
        clear_logs();
        c0 = cyc + 1;
        push_i(32'h400);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                push_d(1'b0, 32'h500, 32'h0, 1'b1);
            end else begin
                n_cmp++;
                if ({m_req, i_gnt, d_gnt} !== 3'b000) begin
                    n_bad++;
                    $display("[TB] FAIL resp_wait[%0d]: got m_req/i_gnt/d_gnt=%b required 000", k, {m_req, i_gnt, d_gnt});
                end
            end
        end
        wait_drain(60, ok);
        n_cmp++;
        if (!ok || i_rv_cyc.size() != 1 || d_gnt_cyc.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL resp_count: got irv=%0d dgnt=%0d required 1/1", i_rv_cyc.size(), d_gnt_cyc.size());
        end else begin
            n_cmp++;
            if (i_rv_cyc[0] != c0 + 5 || d_gnt_cyc[0] != c0 + 6) begin
                n_bad++;
                $display("[TB] FAIL resp_timing: got irv/dgnt at %0d/%0d required 5/6",
                         i_rv_cyc[0] - c0, d_gnt_cyc[0] - c0);
            end
        end
        rsp_delay = 1;
    endtask

    task automatic test_reset_mid();
        int c0;
        bit ok;
        bit seen;
        rsp_delay = 5;
        clear_logs();
        push_i(32'h600);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = (i_gnt_cyc.size() > 0);
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_grant: got no i_gnt required one within 20 cycles");
        end
        @(posedge clk);
        #3 reset = 1'b1;
        i_q.delete();
        d_q.delete();
        exp_req_q.delete();
        exp_rsp_q.delete();
        @(posedge clk);
        #3 reset = 1'b0;
        inject_rv = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_we, m_addr, m_wdata} !== '0) begin
            n_bad++;
            $display("[TB] FAIL late_rvalid: got irv=%b drv=%b m_req=%b required all outputs 0", i_rvalid, d_rvalid, m_req);
        end
        rsp_delay = 1;
        clear_logs();
        c0 = cyc + 1;
        push_i(32'h700);
        wait_drain(30, ok);
        n_cmp++;
        if (!ok || i_gnt_cyc.size() != 1 || i_gnt_cyc[0] != c0) begin
            n_bad++;
            $display("[TB] FAIL reset_idle_grant: got %0d grants, first at %0d, required 1 at 0",
                     i_gnt_cyc.size(), (i_gnt_cyc.size() > 0) ? i_gnt_cyc[0] - c0 : -1);
        end
    endtask

    task automatic test_back_to_back();
        int  c0;
        bit  ok;
        int  want_i[3];
        int  want_d[3];
        // Reset so the round-robin pointer starts from fetch and data wins first.
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        clear_logs();
        c0 = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            i_q.push_back(32'h800 + 32'(4 * k));
            push_d(k[0], 32'h900 + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 1'b0);
        end
`ifdef MEM_ARB_RR_EN
        for (int k = 0; k < 3; k++) begin
            expect_req(1'b1, k[0], 32'h900 + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
            expect_req(1'b0, 1'b0, 32'h800 + 32'(4 * k), 32'h0);
            want_d[k] = 4 * k;
            want_i[k] = 4 * k + 2;
        end
`else
        for (int k = 0; k < 3; k++) begin
            expect_req(1'b1, k[0], 32'h900 + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
            want_d[k] = 2 * k;
            want_i[k] = 6 + 2 * k;
        end
        for (int k = 0; k < 3; k++) begin
            expect_req(1'b0, 1'b0, 32'h800 + 32'(4 * k), 32'h0);
        end
`endif
        wait_drain(60, ok);
        n_cmp++;
        if (!ok || i_gnt_cyc.size() != 3 || d_gnt_cyc.size() != 3) begin
            n_bad++;
            $display("[TB] FAIL b2b_count: got ignt=%0d dgnt=%0d required 3/3", i_gnt_cyc.size(), d_gnt_cyc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (i_gnt_cyc[k] - c0 != want_i[k] || d_gnt_cyc[k] - c0 != want_d[k]) begin
                    n_bad++;
                    $display("[TB] FAIL b2b_timing[%0d]: got ignt/dgnt at %0d/%0d required %0d/%0d",
                             k, i_gnt_cyc[k] - c0, d_gnt_cyc[k] - c0, want_i[k], want_d[k]);
                end
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        gnt_delay = 0;
        rsp_delay = 1;
        inject_rv = 1'b0;
        reset     = 1'b1;
        $display("[TB] starting mem_arbiter bench");
        test_reset();
        test_fetch_stream();
        test_priority();
        test_gnt_stall();
        test_slow_resp();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
